// File: rtl/ps2_frame_rx_if.sv
// PS/2 receiver bus: raw pin inputs plus the validated-byte output group.
// The pin side (master) drives the PS/2 lines; the receiver (slave) drives the results.
interface ps2_frame_rx_if;
    logic       ps2_clk;
    logic       ps2_data;
    logic [7:0] rx_byte;
    logic       rx_valid;
    logic       rx_err;
    logic [1:0] err_code;
    logic       busy;

    modport master (
        output ps2_clk, ps2_data,
        input  rx_byte, rx_valid, rx_err, err_code, busy
    );

    modport slave (
        input  ps2_clk, ps2_data,
        output rx_byte, rx_valid, rx_err, err_code, busy
    );
endinterface

// File: rtl/ps2_frame_rx.sv
// PS/2 device-to-host frame receiver.
// Synchronises and deglitches the PS/2 pins, deserialises 11-bit frames
// (start, 8 data LSB first, odd parity, stop), checks framing and parity,
// aborts on an inter-edge timeout and emits one-cycle valid/error strobes.
module ps2_frame_rx #(
    parameter int CLK_FILTER  = 8,
    parameter int TIMEOUT_CYC = 200000
) (
    input  logic           clk,
    input  logic           rst_n,
    ps2_frame_rx_if.slave  bus
);

    localparam int FW = $clog2(CLK_FILTER + 1);
    localparam int TW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

    localparam logic [1:0] ERR_PARITY  = 2'd1;
    localparam logic [1:0] ERR_STOP    = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DATA   = 2'd1,
        S_PARITY = 2'd2,
        S_STOP   = 2'd3
    } state_t;

    // synchronisers: same depth for clock and data so the sampled bit stays aligned
    logic [1:0]    r_clk_s;
    logic [1:0]    r_dat_s;

    // deglitch filter
    logic          r_clk_f;
    logic [FW-1:0] r_flt_cnt;
    logic          r_fall;

    // frame state
    state_t        r_state;
    logic [2:0]    r_bit_cnt;
    logic [7:0]    r_shreg;
    logic          r_par;
    logic [TW-1:0] r_to_cnt;

    // registered outputs
    logic [7:0]    r_rx_byte;
    logic          r_rx_valid;
    logic          r_rx_err;
    logic [1:0]    r_err_code;
    logic          r_busy;

    logic          w_differ;
    logic          w_flip;
    logic          w_flip_fall;
    logic          w_bit;
    logic          w_to_hit;

    assign w_differ    = (r_clk_s[1] != r_clk_f);
    assign w_flip      = w_differ && (r_flt_cnt == FW'(CLK_FILTER - 1));
    assign w_flip_fall = w_flip && r_clk_f;
    assign w_bit       = r_dat_s[1];
    // abort on the cycle the counter would step onto TIMEOUT_CYC-1, so the
    // error strobe lands exactly TIMEOUT_CYC-1 cycles after the fall strobe
    assign w_to_hit    = (r_state != S_IDLE) && (r_to_cnt == TW'(TIMEOUT_CYC - 2));

    // two-flop synchronisers, idle-high
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_clk_s <= 2'b11;
            r_dat_s <= 2'b11;
        end else begin
            r_clk_s <= {r_clk_s[0], bus.ps2_clk};
            r_dat_s <= {r_dat_s[0], bus.ps2_data};
        end
    end

    // filtered clock flips only after CLK_FILTER consecutive disagreeing cycles; fall strobe on 1->0
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_clk_f   <= 1'b1;
            r_flt_cnt <= '0;
            r_fall    <= 1'b0;
        end else begin
            r_fall <= w_flip_fall;
            if (!w_differ) begin
                r_flt_cnt <= '0;
            end else if (w_flip) begin
                r_clk_f   <= r_clk_s[1];
                r_flt_cnt <= '0;
            end else begin
                r_flt_cnt <= r_flt_cnt + FW'(1);
            end
        end
    end

    // frame FSM with inter-edge timeout; fall edges take priority over timeout
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_bit_cnt  <= '0;
            r_shreg    <= '0;
            r_par      <= 1'b0;
            r_to_cnt   <= '0;
            r_rx_byte  <= '0;
            r_rx_valid <= 1'b0;
            r_rx_err   <= 1'b0;
            r_err_code <= '0;
            r_busy     <= 1'b0;
        end else begin
            r_rx_valid <= 1'b0;
            r_rx_err   <= 1'b0;

            // counter is zero during the fall-strobe cycle itself
            if (w_flip_fall || r_state == S_IDLE || (w_to_hit && !r_fall))
                r_to_cnt <= '0;
            else
                r_to_cnt <= r_to_cnt + TW'(1);

            if (r_fall) begin
                case (r_state)
                    S_IDLE: begin
                        if (!w_bit) begin
                            r_state   <= S_DATA;
                            r_bit_cnt <= '0;
                            r_busy    <= 1'b1;
                        end
                    end
                    S_DATA: begin
                        r_shreg[r_bit_cnt] <= w_bit;
                        r_bit_cnt          <= r_bit_cnt + 3'd1;
                        if (r_bit_cnt == 3'd7)
                            r_state <= S_PARITY;
                    end
                    S_PARITY: begin
                        r_par   <= w_bit;
                        r_state <= S_STOP;
                    end
                    S_STOP: begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                        if (!w_bit) begin
                            r_rx_err   <= 1'b1;
                            r_err_code <= ERR_STOP;
                        end else if (!(^{r_shreg, r_par})) begin
                            r_rx_err   <= 1'b1;
                            r_err_code <= ERR_PARITY;
                        end else begin
                            r_rx_valid <= 1'b1;
                            r_rx_byte  <= r_shreg;
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end else if (w_to_hit) begin
                r_state    <= S_IDLE;
                r_busy     <= 1'b0;
                r_rx_err   <= 1'b1;
                r_err_code <= ERR_TIMEOUT;
            end
        end
    end

    assign bus.rx_byte  = r_rx_byte;
    assign bus.rx_valid = r_rx_valid;
    assign bus.rx_err   = r_rx_err;
    assign bus.err_code = r_err_code;
    assign bus.busy     = r_busy;

endmodule
